param_updown_ctr: RTL

PARAM_UPDOWN_CTR -- requirements
Module: param_updown_ctr

---
 rtl/param_updown_ctr_pkg.sv | 13 +
 rtl/ctr_defs.vh | 8 +
 rtl/ctr_next.sv | 44 ++++
 rtl/param_updown_ctr.sv | 57 +++++
 4 files changed

// File: rtl/param_updown_ctr_pkg.sv
// rtl/param_updown_ctr_pkg.sv - counter defaults, mode encodings and parameter check
package param_updown_ctr_pkg;
`include "ctr_defs.vh"

    localparam int CTR_DEF_WIDTH = `CTR_DEFS_WIDTH;
    localparam int CTR_DEF_MOD   = `CTR_DEFS_MOD;
    localparam int CTR_WRAP      = `CTR_DEFS_WRAP;
    localparam int CTR_SAT       = `CTR_DEFS_SAT;

    function automatic bit ctr_mod_ok(input int width, input int modulus);
        return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
    endfunction
endpackage

// File: rtl/ctr_defs.vh
// rtl/ctr_defs.vh - shared counter defaults and saturate-mode encodings
`ifndef CTR_DEFS_VH
`define CTR_DEFS_VH
`define CTR_DEFS_WIDTH 5
`define CTR_DEFS_MOD   32
`define CTR_DEFS_WRAP  0
`define CTR_DEFS_SAT   1
`endif

// File: rtl/ctr_next.sv
// rtl/ctr_next.sv - next-count and terminal-count logic for the up/down counter
module ctr_next
    import param_updown_ctr_pkg::*;
#(
    parameter int WIDTH    = CTR_DEF_WIDTH,
    parameter int MOD      = CTR_DEF_MOD,
    parameter int SATURATE = CTR_WRAP
) (
    input  logic [WIDTH-1:0] out_i,
    input  logic             up_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] next_o,
    output logic             tc_o
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam int unsigned      MOD_U   = MOD;

    logic at_max;
    logic at_zero;
    logic load_oor;

    assign at_max   = (out_i == MAX_VAL);
    assign at_zero  = (out_i == '0);
    assign load_oor = (32'(load_val_i) >= MOD_U);
    assign tc_o     = en_i & ~load_i & ((up_i & at_max) | (~up_i & at_zero));

    always_comb begin
        next_o = out_i;
        if (load_i) begin
            next_o = load_oor ? MAX_VAL : load_val_i;
        end else if (en_i) begin
            // At a bound the saturate mode picks between holding and wrapping.
            if (up_i) begin
                if (at_max) next_o = (SATURATE == CTR_SAT) ? MAX_VAL : '0;
                else        next_o = out_i + WIDTH'(1);
            end else begin
                if (at_zero) next_o = (SATURATE == CTR_SAT) ? '0 : MAX_VAL;
                else         next_o = out_i - WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/param_updown_ctr.sv
// rtl/param_updown_ctr.sv - modulo-N up/down counter with load, terminal count and overflow pulse
module param_updown_ctr
    import param_updown_ctr_pkg::*;
#(
    parameter int WIDTH    = CTR_DEF_WIDTH,
    parameter int MOD      = CTR_DEF_MOD,
    parameter int SATURATE = CTR_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             ovf_q;
    logic             ovf_d;

    if (!ctr_mod_ok(WIDTH, MOD)) begin : g_bad_mod
        $error("param_updown_ctr: MOD=%0d outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
    end

    ctr_next #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .SATURATE (SATURATE)
    ) u_next (
        .out_i      (out_q),
        .up_i       (up),
        .en_i       (en),
        .load_i     (load),
        .load_val_i (load_val),
        .next_o     (out_d),
        .tc_o       (tc)
    );

    // ovf marks the edge on which a boundary was crossed or held.
    assign ovf_d = tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out = out_q;
    assign ovf = ovf_q;
endmodule
